// File: rtl/tdes_pkg.sv
// rtl/tdes_pkg.sv - state type, DES permutation tables and rotation schedules for the TDES key schedule
package tdes_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ROUND, ST_DONE} state_t;

  // Table entries are DES bit numbers: 1-based, counted from the MSB
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam logic [1:0] S_ROT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // Right-rotation schedule walks the left schedule backwards, so a decrypt pass yields K16..K1
  localparam logic [1:0] R_ROT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n,
                                        input logic right);
    logic [27:0] y;
    case ({right, n})
      3'b001:  y = {x[26:0], x[27]};
      3'b010:  y = {x[25:0], x[27:26]};
      3'b101:  y = {x[0], x[27:1]};
      3'b110:  y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    logic [5:0]  j;
    cd = '0;
    for (j = 6'd0; j < 6'd56; j++) begin
      cd[6'(55 - j)] = key[6'(64 - PC1[j])];
    end
    return cd;
  endfunction

endpackage

// File: rtl/des_pc2_perm.sv
// rtl/des_pc2_perm.sv - combinational PC2 compression of the 56-bit C/D pair into a 48-bit subkey
module des_pc2_perm
  import tdes_pkg::*;
(
  input  logic [55:0] i_cd,
  output logic [47:0] o_subkey
);

  always_comb begin : pc2_map
    logic [5:0] j;
    o_subkey = '0;
    for (j = 6'd0; j < 6'd48; j++) begin
      o_subkey[6'(47 - j)] = i_cd[6'(56 - PC2[j])];
    end
  end

endmodule

// File: rtl/tdes_key_schedule.sv
// rtl/tdes_key_schedule.sv - iterative EDE triple-DES subkey generator, one subkey per handshake
module tdes_key_schedule
  import tdes_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        enable,
  input  logic        encryption_type,
  input  logic [63:0] key1,
  input  logic [63:0] key2,
  input  logic [63:0] key3,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round_num,
  output logic [1:0]  pass_num,
  output logic        pass_decrypt,
  output logic        busy,
  output logic        done
);

  state_t      r_state;
  logic [63:0] r_key1, r_key2, r_key3;
  logic        r_enc;
  logic [27:0] r_c, r_d;
  logic [3:0]  r_round;
  logic [1:0]  r_pass;
  logic        r_pass_dec, r_valid, r_busy, r_done;

  logic [63:0] w_pass_key;
  logic        w_pass_dec;
  logic [55:0] w_pc1;
  logic [1:0]  w_load_rot, w_next_rot;
  logic [3:0]  w_next_round;
  logic        w_hs;

  // Encrypt walks K1,K2,K3; decrypt walks K3,K2,K1
  always_comb begin
    w_pass_key = r_key2;
    if (r_pass == 2'd0) w_pass_key = r_enc ? r_key1 : r_key3;
    else if (r_pass == 2'd2) w_pass_key = r_enc ? r_key3 : r_key1;
  end

  assign w_pass_dec   = (r_pass == 2'd1) ? r_enc : ~r_enc;
  assign w_pc1        = pc1(w_pass_key);
  assign w_load_rot   = w_pass_dec ? R_ROT[0] : S_ROT[0];
  assign w_next_round = r_round + 4'd1;
  assign w_next_rot   = r_pass_dec ? R_ROT[w_next_round] : S_ROT[w_next_round];
  assign w_hs         = r_valid & subkey_ready;

  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      r_state    <= ST_IDLE;
      r_key1     <= '0;
      r_key2     <= '0;
      r_key3     <= '0;
      r_enc      <= 1'b0;
      r_c        <= '0;
      r_d        <= '0;
      r_round    <= '0;
      r_pass     <= '0;
      r_pass_dec <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (enable) begin
          r_key1  <= key1;
          r_key2  <= key2;
          r_key3  <= key3;
          r_enc   <= encryption_type;
          r_pass  <= 2'd0;
          r_busy  <= 1'b1;
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_c        <= rot28(w_pc1[55:28], w_load_rot, w_pass_dec);
          r_d        <= rot28(w_pc1[27:0], w_load_rot, w_pass_dec);
          r_pass_dec <= w_pass_dec;
          r_round    <= 4'd0;
          r_valid    <= 1'b1;
          r_state    <= ST_ROUND;
        end
        ST_ROUND: if (w_hs) begin
          if (r_round != 4'd15) begin
            r_round <= w_next_round;
            r_c     <= rot28(r_c, w_next_rot, r_pass_dec);
            r_d     <= rot28(r_d, w_next_rot, r_pass_dec);
          end else begin
            r_valid <= 1'b0;
            if (r_pass != 2'd2) begin
              r_pass  <= r_pass + 2'd1;
              r_state <= ST_LOAD;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  des_pc2_perm u_pc2 (
    .i_cd     ({r_c, r_d}),
    .o_subkey (subkey)
  );

  assign subkey_valid = r_valid;
  assign round_num    = r_round;
  assign pass_num     = r_pass;
  assign pass_decrypt = r_pass_dec;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_tdes_key_schedule.sv
// tb/tb_tdes_key_schedule.sv - table-driven checks of the TDES key schedule against a textbook DES key model
module tb_tdes_key_schedule;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        enable;
  logic        encryption_type;
  logic [63:0] key1, key2, key3;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_num;
  logic [1:0]  pass_num;
  logic        pass_decrypt;
  logic        busy;
  logic        done;

  tdes_key_schedule dut (
    .HCLK            (HCLK),
    .HRESET          (HRESET),
    .enable          (enable),
    .encryption_type (encryption_type),
    .key1            (key1),
    .key2            (key2),
    .key3            (key3),
    .subkey_ready    (subkey_ready),
    .subkey          (subkey),
    .subkey_valid    (subkey_valid),
    .round_num       (round_num),
    .pass_num        (pass_num),
    .pass_decrypt    (pass_decrypt),
    .busy            (busy),
    .done            (done)
  );

  always #5 HCLK = ~HCLK;

  localparam logic [63:0] KA  = 64'h133457799BBCDFF1;
  localparam logic [47:0] SK1 = 48'h1B02EFFC7072;
  localparam logic [47:0] SK16 = 48'hCB3D8B0E17F5;

  int TB_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  int TB_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int TB_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef logic [47:0] ks_t [16];

  typedef struct {
    logic [63:0] k1, k2, k3;
    logic        enc;
    logic [47:0] exp_first, exp_last;
    logic        has_p1;
    logic [47:0] p1_first, p1_last;
    int          stall_len;
    logic        disturb;
  } vec_t;

  vec_t vecs [5];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Standard forward DES schedule: K1..K16 by cumulative left shifts of C0/D0
  task automatic make_ks(input logic [63:0] key, output ks_t ks);
    logic [55:0] cd, u;
    logic [63:0] t;
    logic [27:0] c, d;
    logic [47:0] k;
    cd = '0;
    for (int j = 0; j < 56; j++) begin
      t  = key >> (64 - TB_PC1[j]);
      cd = {cd[54:0], t[0]};
    end
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < TB_SH[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      k = '0;
      for (int j = 0; j < 48; j++) begin
        u = {c, d} >> (56 - TB_PC2[j]);
        k = {k[46:0], u[0]};
      end
      ks[i] = k;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_subkey"}, subkey, 0);
    check({tag, "_valid"}, subkey_valid, 0);
    check({tag, "_round"}, round_num, 0);
    check({tag, "_pass"}, pass_num, 0);
    check({tag, "_pdec"}, pass_decrypt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic run_vec(input vec_t v);
    ks_t         ks1, ks2, ks3, kp;
    logic [47:0] exp;
    logic        pdec, fin;
    int          k, hs, stalled, loads, p, r;
    make_ks(v.k1, ks1);
    make_ks(v.k2, ks2);
    make_ks(v.k3, ks3);
    key1 = v.k1; key2 = v.k2; key3 = v.k3;
    encryption_type = v.enc;
    subkey_ready = 1'b1;
    enable = 1'b1;
    @(negedge HCLK);
    enable = 1'b0;
    check("start_busy", busy, 1);
    check("start_valid", subkey_valid, 0);
    k = 1; hs = 0; stalled = 0; loads = 0; fin = 1'b0;
    while (!fin && k < 150) begin
      @(negedge HCLK);
      k++;
      enable = 1'b0;
      if (done) begin
        check("done_cycle", k, 52 + v.stall_len);
        check("done_hs", hs, 48);
        check("done_busy", busy, 1);
        fin = 1'b1;
        if (v.disturb) enable = 1'b1;
      end else if (subkey_valid) begin
        p = hs / 16;
        r = hs % 16;
        if (p == 1) kp = ks2;
        else if ((p == 0) == v.enc) kp = ks1;
        else kp = ks3;
        pdec = (p == 1) ? v.enc : !v.enc;
        exp  = pdec ? kp[15 - r] : kp[r];
        check("subkey", subkey, exp);
        check("round_num", round_num, r);
        check("pass_num", pass_num, p);
        check("pass_decrypt", pass_decrypt, pdec);
        if (hs == 0) begin
          check("first_valid_cycle", k, 2);
          check("hand_p0_first", subkey, v.exp_first);
        end
        if (hs == 15) check("hand_p0_last", subkey, v.exp_last);
        if (v.has_p1 && hs == 16) check("hand_p1_first", subkey, v.p1_first);
        if (v.has_p1 && hs == 31) check("hand_p1_last", subkey, v.p1_last);
        if (v.stall_len > 0 && hs == 23 && stalled < v.stall_len) begin
          subkey_ready = 1'b0;
          stalled++;
        end else begin
          subkey_ready = 1'b1;
          hs++;
        end
        if (v.disturb && (k == 5 || k == 30)) begin
          enable = 1'b1;
          key1 = ~v.k1;
          encryption_type = ~v.enc;
        end
      end else begin
        loads++;
        check("load_boundary", hs % 16, 0);
        check("load_busy", busy, 1);
      end
    end
    check("done_seen", fin, 1);
    check("load_count", loads, 2);
    @(negedge HCLK);
    enable = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    if (v.disturb) begin
      @(negedge HCLK);
      check("no_restart_from_done", busy, 0);
    end
    key1 = v.k1;
    encryption_type = v.enc;
  endtask

  initial begin
    int dcount;
    vecs[0] = '{KA, KA, KA, 1'b1, SK1, SK16, 1'b1, SK16, SK1, 0, 1'b0};
    vecs[1] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, KA, 1'b0, SK16, SK1, 1'b0, 48'h0, 48'h0, 0, 1'b0};
    vecs[2] = '{KA, KA, KA, 1'b1, SK1, SK16, 1'b1, SK16, SK1, 5, 1'b0};
    vecs[3] = '{KA, 64'hA5A5A5A55A5A5A5A, 64'h0F1E2D3C4B5A6978, 1'b1, SK1, SK16, 1'b0, 48'h0, 48'h0, 0, 1'b1};
    vecs[4] = '{KA, KA, KA, 1'b0, SK16, SK1, 1'b1, SK1, SK16, 0, 1'b0};

    HRESET = 1'b0;
    enable = 1'b1;
    encryption_type = 1'b1;
    key1 = KA; key2 = KA; key3 = KA;
    subkey_ready = 1'b1;
    repeat (3) @(negedge HCLK);
    check_all_zero("reset");
    HRESET = 1'b1;
    enable = 1'b0;
    @(negedge HCLK);
    check("post_reset_idle", busy, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort mid-pass: reset while streaming, with enable held high through reset
    key1 = KA; key2 = KA; key3 = KA;
    encryption_type = 1'b1;
    enable = 1'b1;
    @(negedge HCLK);
    enable = 1'b0;
    repeat (8) @(negedge HCLK);
    check("midrun_valid", subkey_valid, 1);
    HRESET = 1'b0;
    enable = 1'b1;
    @(negedge HCLK);
    check_all_zero("midrun_reset");
    @(negedge HCLK);
    check("reset_enable_ignored", busy, 0);
    HRESET = 1'b1;
    enable = 1'b0;
    dcount = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge HCLK);
      if (done || busy) dcount++;
    end
    check("no_activity_after_abort", dcount, 0);

    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
